// File: rtl/fp_pkg.sv
// Shared constants and stage payload for the single-precision adder datapath.
package fp_pkg;

  localparam int unsigned MW      = 27;
  localparam int unsigned EW      = 8;
  localparam int unsigned XW      = 10;
  localparam int unsigned EXP_MAX = 255;
  localparam int unsigned BIAS    = 127;
  localparam int unsigned HID_POS = 26;
  localparam int unsigned LSB_POS = 3;
  localparam int unsigned G_POS   = 2;
  localparam int unsigned R_POS   = 1;
  localparam int unsigned S_POS   = 0;

  // Stage-1 to stage-2 payload: raw sum, add carry, effective exponent, sign.
  typedef struct packed {
    logic [MW-1:0] sum;
    logic          carry;
    logic [EW-1:0] exp;
    logic          sign;
  } s1_t;

endpackage

// File: rtl/fp_add_normalize_lzc27.sv
// Combinational leading-zero counter over 27 bits; all-zero input yields 27.
module lzc27 (
  input  logic [26:0] din,
  output logic [4:0]  count
);

  // Ascending scan: the highest set bit is the last one to write the count.
  always_comb begin
    count = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (din[i]) count = 5'(26 - i);
    end
  end

endmodule

// File: rtl/fp_add_normalize.sv
// Add aligned significands, normalize, round to nearest-even and pack an
// IEEE-754 single; two-stage valid/ready pipeline.
module fp_add_normalize #(
  parameter int unsigned MW = 27,
  parameter int unsigned EW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [MW-1:0] op_a,
  input  logic [MW-1:0] op_b,
  input  logic          eop,
  input  logic [EW-1:0] e_big,
  input  logic          sign_res,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   result,
  output logic          ovf,
  output logic          zero
);

  import fp_pkg::*;

  logic        s1_valid;
  s1_t         s1;
  s1_t         s1_next;
  logic        adv1;
  logic        adv2;
  logic [27:0] sum_w;

  logic [4:0]    lz;
  logic [XW-1:0] e_ext;
  logic [XW-1:0] lim;
  logic [XW-1:0] sh;
  logic [XW-1:0] exp_n;
  logic [XW-1:0] exp_r;
  logic [26:0]   norm;
  logic          inc;
  logic [24:0]   rnd;
  logic [23:0]   mant;
  logic          is_zero;
  logic          is_ovf;
  logic [31:0]   res_next;

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1 && !RST;

  // Stage 1: carry out is meaningless on subtract, so it is dropped there.
  always_comb begin
    sum_w         = {1'b0, op_a} + {1'b0, op_b} + 28'(eop);
    s1_next.sum   = sum_w[26:0];
    s1_next.carry = sum_w[27] && !eop;
    s1_next.exp   = (e_big == '0) ? 8'd1 : e_big;
    s1_next.sign  = sign_res;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid <= 1'b0;
    end else if (adv1) begin
      s1_valid <= in_valid;
    end
  end

  always_ff @(posedge CLK) begin
    if (adv1 && in_valid) s1 <= s1_next;
  end

  lzc27 u_lzc (
    .din   (s1.sum),
    .count (lz)
  );

  // Stage 2: normalize (left shift clamped at the subnormal limit), RNE, pack.
  always_comb begin
    e_ext = XW'(s1.exp);
    lim   = e_ext - 10'd1;
    sh    = '0;
    norm  = s1.sum;
    exp_n = e_ext;
    if (s1.carry) begin
      norm  = {1'b1, s1.sum[26:2], s1.sum[1] | s1.sum[0]};
      exp_n = e_ext + 10'd1;
    end else begin
      sh    = (XW'(lz) < lim) ? XW'(lz) : lim;
      norm  = s1.sum << sh;
      exp_n = e_ext - sh;
    end

    inc = norm[G_POS] & (norm[R_POS] | norm[S_POS] | norm[LSB_POS]);
    rnd = {1'b0, norm[HID_POS:LSB_POS]} + 25'(inc);
    if (rnd[24]) begin
      mant  = rnd[24:1];
      exp_r = exp_n + 10'd1;
    end else begin
      mant  = rnd[23:0];
      exp_r = exp_n;
    end

    is_zero = !s1.carry && (s1.sum == '0);
    is_ovf  = !is_zero && (exp_r >= XW'(EXP_MAX));
    if (is_zero) begin
      res_next = 32'h0000_0000;
    end else if (is_ovf) begin
      res_next = {s1.sign, 8'hFF, 23'h0};
    end else begin
      res_next = {s1.sign, (mant[23] ? exp_r[7:0] : 8'd0), mant[22:0]};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result <= res_next;
        ovf    <= is_ovf;
        zero   <= is_zero;
      end
    end
  end

endmodule

// File: tb/tb_fp_add_normalize.sv
// Scoreboard bench for fp_add_normalize: directed vectors, backpressure,
// output stability and mid-flight reset.
module tb_fp_add_normalize;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [26:0] op_a;
  logic [26:0] op_b;
  logic        eop;
  logic [7:0]  e_big;
  logic        sign_res;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        ovf;
  logic        zero;

  int total = 0;
  int bad   = 0;
  int acc_count = 0;
  logic [33:0] exp_q[$];
  logic [33:0] cur_exp;
  logic        stall_prev = 1'b0;
  logic [33:0] stall_val;

  typedef struct packed {
    logic [26:0] a;
    logic [26:0] b;
    logic        eop;
    logic [7:0]  e;
    logic        sign;
    logic [31:0] res;
    logic        ovf;
    logic        zero;
  } vec_t;

  vec_t vecs[$];

  always #5 CLK = ~CLK;

  fp_add_normalize dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .eop       (eop),
    .e_big     (e_big),
    .sign_res  (sign_res),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf),
    .zero      (zero)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Monitor at the falling edge: inputs and registered outputs are both settled.
  always @(negedge CLK) begin
    if (!RST) begin
      if (stall_prev && out_valid)
        check("stable", 64'({result, ovf, zero}), 64'(stall_val));
      if (in_valid && in_ready) begin
        exp_q.push_back(cur_exp);
        acc_count++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 64'(1), 64'(0));
        end else begin
          check("result", 64'({result, ovf, zero}), 64'(exp_q.pop_front()));
        end
      end
    end
    stall_prev = out_valid && !out_ready && !RST;
    stall_val  = {result, ovf, zero};
  end

  task automatic drive(input vec_t v);
    op_a     = v.a;
    op_b     = v.b;
    eop      = v.eop;
    e_big    = v.e;
    sign_res = v.sign;
    cur_exp  = {v.res, v.ovf, v.zero};
    in_valid = 1'b1;
  endtask

  task automatic send(input vec_t v);
    logic ok;
    ok = 1'b0;
    drive(v);
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("send_timeout", 64'(ok), 64'(1));
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge CLK);
    @(negedge CLK);
    check(tag, 64'(exp_q.size()), 64'(0));
  endtask

  function automatic vec_t mk(input logic [26:0] a, input logic [26:0] b, input logic e_op,
                              input logic [7:0] e, input logic s, input logic [31:0] r,
                              input logic o, input logic z);
    vec_t v;
    v.a = a; v.b = b; v.eop = e_op; v.e = e; v.sign = s;
    v.res = r; v.ovf = o; v.zero = z;
    return v;
  endfunction

  initial begin
    RST = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op_a = '0; op_b = '0; eop = 1'b0; e_big = '0; sign_res = 1'b0; cur_exp = '0;

    vecs.push_back(mk(27'h4000000, 27'h4000000, 1'b0, 8'd127, 1'b0, 32'h40000000, 1'b0, 1'b0));
    vecs.push_back(mk(27'h4000000, ~27'h4000000, 1'b1, 8'd127, 1'b0, 32'h00000000, 1'b0, 1'b1));
    vecs.push_back(mk(27'h6000000, ~27'h4000000, 1'b1, 8'd127, 1'b0, 32'h3F000000, 1'b0, 1'b0));
    vecs.push_back(mk(27'h4000004, 27'h0, 1'b0, 8'd127, 1'b0, 32'h3F800000, 1'b0, 1'b0));
    vecs.push_back(mk(27'h400000C, 27'h0, 1'b0, 8'd127, 1'b0, 32'h3F800002, 1'b0, 1'b0));
    vecs.push_back(mk(27'h7FFFFF8, 27'h7FFFFF8, 1'b0, 8'd254, 1'b0, 32'h7F800000, 1'b1, 1'b0));
    vecs.push_back(mk(27'h7FFFFF8, 27'h7FFFFF8, 1'b0, 8'd254, 1'b1, 32'hFF800000, 1'b1, 1'b0));
    vecs.push_back(mk(27'h4000000, 27'h4000000, 1'b0, 8'd127, 1'b1, 32'hC0000000, 1'b0, 1'b0));
    vecs.push_back(mk(27'h4000000, ~27'h4000000, 1'b1, 8'd127, 1'b1, 32'h00000000, 1'b0, 1'b1));
    vecs.push_back(mk(27'h7FFFFFC, 27'h0, 1'b0, 8'd127, 1'b0, 32'h40000000, 1'b0, 1'b0));
    vecs.push_back(mk(27'h0000008, 27'h0, 1'b0, 8'd0, 1'b0, 32'h00000001, 1'b0, 1'b0));
    vecs.push_back(mk(27'h2000000, 27'h2000000, 1'b0, 8'd1, 1'b0, 32'h00800000, 1'b0, 1'b0));

    repeat (2) @(negedge CLK);
    check("rst_in_ready", 64'(in_ready), 64'(0));
    @(posedge CLK); #1; RST = 1'b0;
    @(negedge CLK);
    check("post_rst_in_ready", 64'(in_ready), 64'(1));
    check("post_rst_out", 64'({out_valid, result, ovf, zero}), 64'(0));

    // Latency: single beat, out_valid rises at the second edge after accept.
    @(posedge CLK); #1;
    send(vecs[0]);
    @(negedge CLK);
    check("lat_cycle1", 64'(out_valid), 64'(0));
    @(negedge CLK);
    check("lat_cycle2", 64'(out_valid), 64'(1));
    drain("drain_lat");

    // Back-to-back directed vectors.
    @(posedge CLK); #1;
    foreach (vecs[i]) send(vecs[i]);
    drain("drain_vecs");

    // Backpressure: only two beats fit, third waits, drained in order.
    @(posedge CLK); #1;
    out_ready = 1'b0;
    acc_count = 0;
    send(vecs[2]);
    send(vecs[4]);
    drive(vecs[5]);
    repeat (3) @(negedge CLK);
    check("bp_accepted", 64'(acc_count), 64'(2));
    check("bp_in_ready", 64'(in_ready), 64'(0));
    check("bp_out_valid", 64'(out_valid), 64'(1));
    @(posedge CLK); #1;
    out_ready = 1'b1;
    @(negedge CLK);
    check("bp_accept3", 64'(in_ready), 64'(1));
    @(posedge CLK); #1;
    in_valid = 1'b0;
    drain("drain_bp");
    check("bp_total", 64'(acc_count), 64'(3));

    // Reset with two beats in flight drops them.
    @(posedge CLK); #1;
    out_ready = 1'b0;
    send(vecs[7]);
    send(vecs[9]);
    @(negedge CLK);
    check("rf_full", 64'(out_valid), 64'(1));
    @(posedge CLK); #1;
    RST = 1'b1;
    exp_q.delete();
    @(negedge CLK);
    check("rf_in_ready", 64'(in_ready), 64'(0));
    @(negedge CLK);
    check("rf_out_valid", 64'(out_valid), 64'(0));
    @(posedge CLK); #1;
    RST = 1'b0;
    out_ready = 1'b1;
    @(negedge CLK);
    check("rf_after", 64'({out_valid, result, ovf, zero}), 64'(0));
    repeat (5) @(posedge CLK);

    // Traffic resumes normally after the flush.
    #1;
    send(vecs[3]);
    send(vecs[5]);
    drain("drain_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
